dual_port_regfile_be: RTL and testbench
=======================================

# dual_port_regfile_be

Parametrised 1-write/1-read register file with arbitrary per-byte write enables, configurable read latency and a hardware clear sequencer. It is the general-width successor to the single-port byte-write register: independent read and write ports, no destructive writes on unsupported masks, and known contents after reset. It sits behind core-side load/store and scratchpad logic wherever a 1W1R array with byte granularity is needed.

## Interface
- `WIDTH`, 32: data width in bits; must be a multiple of 8, at least 8.
- `DEPTH`, 1024: number of entries; at least 2.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: address width.
- `READ_LATENCY`, 1: cycles from `rd_en` to `rd_valid`; legal values are 1 or 2.
- `BE_WIDTH`, `WIDTH/8`: byte-enable width; derived, never overridden.
- `clk`, input, 1: the single clock. All logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `busy`, output, 1: clear sequence in progress. Reset value 1.
- `wr_en`, input, 1: write request.
- `wr_be`, input, `BE_WIDTH`: byte enables. Bit i covers `wr_data[8i+7:8i]`.
- `wr_addr`, input, `ADDR_WIDTH`: write address.
- `wr_data`, input, `WIDTH`: write data.
- `rd_en`, input, 1: read request.
- `rd_addr`, input, `ADDR_WIDTH`: read address.
- `rd_data`, output, `WIDTH`: read data. Reset value 0. Holds its last value when `rd_valid` is low.
- `rd_valid`, output, 1: one-cycle pulse per accepted read. Reset value 0.

## Operation
- FSM states: `CLEAR` and `READY`.
  - `rst` forces `CLEAR` with the clear pointer at 0.
  - In `CLEAR`, one entry is zeroed per cycle, pointer +1.
  - After entry `DEPTH-1` is written, the FSM moves to `READY` and `busy` falls.
  - `busy` is high for exactly `DEPTH` cycles after `rst` deasserts.
- While `busy` is high, `wr_en` and `rd_en` are ignored: no write, no `rd_valid`. There is no backpressure; the requester must gate on `busy`.
- Write (READY, `wr_en`=1): for each i with `wr_be[i]`=1, byte i of `mem[wr_addr]` takes `wr_data` byte i. Other bytes are unchanged. Any mask is legal, including non-contiguous masks. `wr_be`=0 is a no-op; it never clears the entry.
- Read (READY, `rd_en`=1): `mem[rd_addr]` is captured and presented after `READ_LATENCY` cycles with `rd_valid`=1.
  - Back-to-back reads are fully pipelined, one per cycle.
  - The `rd_valid` pulses keep the request order.
- Simultaneous read and write to different addresses proceed independently.
- Same-address collision: behaviour is set by `REGFILE_BYPASS_EN`.
- `rst` mid-operation: in-flight reads are dropped (`rd_valid` forced 0, `rd_data` forced 0). The clear sequence restarts from 0.
- Out-of-range addresses (DEPTH not a power of two): writes are dropped; reads return 0 with `rd_valid`=1.

## Timing
- `READ_LATENCY`=1: request at edge N, data and `rd_valid` registered at edge N+1.
- `READ_LATENCY`=2: one extra output register; data at edge N+2.
- A write at edge N is visible to a read requested at edge N+1 or later, regardless of the macro.
- First accepted request: on the cycle after `busy` is sampled low.

## Configuration
- Macro `REGFILE_BYPASS_EN` controls the same-cycle same-address read/write case.
- Defined (write-first): the read returns the merged word. Bytes with `wr_be`=1 come from `wr_data`; the rest come from the old contents.
- Undefined (read-first): the read returns the pre-write contents. This saves the bypass mux and compare.

## Structure
- Package `regfile_pkg` holds:
  - the state enum `regfile_state_e` (`CLEAR`, `READY`);
  - the `BYTE_BITS`=8 constant;
  - the function `be_merge(old, new, be)`, which is shared by the write path and the bypass.
- One sub-module, `regfile_clear_seq`, is natural. It owns the FSM, the clear pointer and `busy`, and drives the internal write override into the array.

## Test plan
- Reset then idle (DEPTH=16): `busy`=1 for exactly 16 cycles, then 0. Reading all 16 addresses returns 0x00000000 with one `rd_valid` each.
- Write 0xDEADBEEF with be=0xF to addr 3, then write 0x11223344 with be=0x5 to addr 3, then read addr 3: returns 0xDE22BE44. A later write with be=0x0 leaves it at 0xDE22BE44.
- Same-cycle write 0xAABBCCDD with be=0xC and read of addr 5, where addr 5 holds 0x01020304: returns 0xAABB0304 with the macro defined, 0x01020304 without.
- READ_LATENCY=2 with reads of addrs 0,1,2 on consecutive cycles: three consecutive `rd_valid` pulses starting 2 cycles after the first request, in order 0,1,2.
- `rst` asserted one cycle after a read request: no `rd_valid`, `rd_data`=0, `busy` returns to 1, and all entries read 0 after the clear completes.
- Requests issued while `busy`=1: a write to addr 7 is not committed and produces no `rd_valid`. After the clear, addr 7 reads 0.

Source files
------------

// File: rtl/dual_port_regfile_be_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared types and helpers for the dual_port_regfile_be block.
//   regfile_state_e : clear-sequencer states (CLEAR, READY)
//   BYTE_BITS       : bits per byte lane
//   be_merge()      : byte-enable merge used by both the write path and the
//                     write-first bypass, so the two can never disagree.
// be_merge works on a fixed maximum width (MERGE_MAX_WIDTH); callers
// zero-extend their operands and truncate the result back to WIDTH.
// ---------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } regfile_state_e;

  localparam int BYTE_BITS       = 8;
  localparam int MERGE_MAX_WIDTH = 512;
  localparam int MERGE_MAX_BYTES = MERGE_MAX_WIDTH / BYTE_BITS;

  // Bytes whose enable is set come from new_word, all others from old_word.
  function automatic logic [MERGE_MAX_WIDTH-1:0] be_merge(
    input logic [MERGE_MAX_WIDTH-1:0] old_word,
    input logic [MERGE_MAX_WIDTH-1:0] new_word,
    input logic [MERGE_MAX_BYTES-1:0] be
  );
    logic [MERGE_MAX_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_MAX_BYTES; i++) begin
      if (be[i]) begin
        merged[i*BYTE_BITS +: BYTE_BITS] = new_word[i*BYTE_BITS +: BYTE_BITS];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dual_port_regfile_be_if.sv
// ---------------------------------------------------------------------------
// dual_port_regfile_be_if
// Request/response bundle between a requester and dual_port_regfile_be.
//   busy     : clear sequence in progress, requests are ignored
//   wr_en    : write request          wr_be   : per-byte write enables
//   wr_addr  : write address          wr_data : write data
//   rd_en    : read request           rd_addr : read address
//   rd_data  : read data (held while rd_valid is low)
//   rd_valid : one-cycle pulse per accepted read
// Modports: master = requester side, slave = register file side.
// ---------------------------------------------------------------------------
interface dual_port_regfile_be_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
);
  import regfile_pkg::*;

  localparam int BE_WIDTH = WIDTH / BYTE_BITS;

  logic                  busy;
  logic                  wr_en;
  logic [BE_WIDTH-1:0]   wr_be;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;

  modport master (
    output wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    input  busy, rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    output busy, rd_data, rd_valid
  );

endinterface

// File: rtl/dual_port_regfile_be_clear_seq.sv
// ---------------------------------------------------------------------------
// regfile_clear_seq
// Post-reset clear sequencer: walks every entry once, zeroing one per cycle,
// then releases the array for normal traffic.
//   clk        : clock
//   rst        : synchronous active-high reset, restarts the sequence at 0
//   clr_we_o   : write override into the array (zero the entry at clr_addr_o)
//   clr_addr_o : entry currently being cleared
//   busy_o     : high from reset until the last entry has been cleared
// ---------------------------------------------------------------------------
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o,
  output logic                  busy_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  regfile_state_e        state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          // The entry at ptr_q is zeroed on this same edge; leaving after the
          // last one gives exactly DEPTH busy cycles.
          if (ptr_q == LAST_ADDR) begin
            state_q <= READY;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + ADDR_WIDTH'(1);
          end
        end
        READY: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = ptr_q;
  assign busy_o     = busy_q;

endmodule

// File: rtl/dual_port_regfile_be.sv
// ---------------------------------------------------------------------------
// dual_port_regfile_be
// 1-write/1-read register file with per-byte write enables, 1- or 2-cycle
// registered read and a hardware clear after reset.
//   clk : clock              rst : synchronous active-high reset
//   bus : dual_port_regfile_be_if.slave (busy, write port, read port)
// Parameters: WIDTH (multiple of 8, <= 512), DEPTH (>= 2), ADDR_WIDTH,
//             READ_LATENCY (1 or 2). BE_WIDTH is derived from WIDTH.
// Build option: REGFILE_BYPASS_EN
//   defined   -> same-cycle same-address read returns the merged new word
//   undefined -> same-cycle same-address read returns the old contents
// Out-of-range addresses (non power-of-two DEPTH): writes are dropped and
// reads return zero with rd_valid.
// ---------------------------------------------------------------------------
module dual_port_regfile_be
  import regfile_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int READ_LATENCY = 1
) (
  input logic                   clk,
  input logic                   rst,
  dual_port_regfile_be_if.slave bus
);

  localparam int               BE_WIDTH = WIDTH / BYTE_BITS;
  localparam logic [31:0]      DEPTH_U  = 32'(DEPTH);

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_busy;

  regfile_clear_seq #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .busy_o     (clr_busy)
  );

  assign bus.busy = clr_busy;

  logic [WIDTH-1:0] mem [DEPTH];

  // Requests are only honoured once the clear has finished and outside reset.
  logic ready;
  logic wr_in_range;
  logic rd_in_range;
  logic wr_fire;
  logic rd_fire;

  assign ready       = !clr_busy && !rst;
  assign wr_in_range = (32'(bus.wr_addr) < DEPTH_U);
  assign rd_in_range = (32'(bus.rd_addr) < DEPTH_U);
  assign wr_fire     = ready && bus.wr_en && wr_in_range;
  assign rd_fire     = ready && bus.rd_en;

  logic [BE_WIDTH-1:0] wr_be;
  logic [WIDTH-1:0]    wr_merged;

  assign wr_be     = bus.wr_be;
  assign wr_merged = WIDTH'(be_merge(MERGE_MAX_WIDTH'(mem[bus.wr_addr]),
                                     MERGE_MAX_WIDTH'(bus.wr_data),
                                     MERGE_MAX_BYTES'(wr_be)));

  // Clear override has priority; the two never overlap outside reset since
  // wr_fire requires the clear to be finished.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      mem[bus.wr_addr] <= wr_merged;
    end
  end

  // Word captured by an accepted read.
  logic [WIDTH-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[bus.rd_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_fire && (bus.wr_addr == bus.rd_addr)) begin
        rd_word = wr_merged;
      end
`endif
    end
  end

  // First read stage: data register only loads on an accepted read so the
  // output holds its last value between pulses.
  logic             rd_valid_s1_q;
  logic [WIDTH-1:0] rd_data_s1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_s1_q <= 1'b0;
      rd_data_s1_q  <= '0;
    end else begin
      rd_valid_s1_q <= rd_fire;
      if (rd_fire) begin
        rd_data_s1_q <= rd_word;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic             rd_valid_s2_q;
      logic [WIDTH-1:0] rd_data_s2_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_valid_s2_q <= 1'b0;
          rd_data_s2_q  <= '0;
        end else begin
          rd_valid_s2_q <= rd_valid_s1_q;
          if (rd_valid_s1_q) begin
            rd_data_s2_q <= rd_data_s1_q;
          end
        end
      end

      assign bus.rd_valid = rd_valid_s2_q;
      assign bus.rd_data  = rd_data_s2_q;
    end else begin : g_lat1
      assign bus.rd_valid = rd_valid_s1_q;
      assign bus.rd_data  = rd_data_s1_q;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_regfile_be.sv
// ---------------------------------------------------------------------------
// tb_dual_port_regfile_be
// Directed bench for dual_port_regfile_be: two instances (READ_LATENCY 1 and
// 2, DEPTH 16, WIDTH 32) receive identical stimulus; every expected word is a
// hand-computed constant.
// ---------------------------------------------------------------------------
module tb_dual_port_regfile_be;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dual_port_regfile_be_if #(.WIDTH(32), .ADDR_WIDTH(4)) bus1 ();
  dual_port_regfile_be_if #(.WIDTH(32), .ADDR_WIDTH(4)) bus2 ();

  dual_port_regfile_be #(
    .WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .READ_LATENCY(1)
  ) u_dut_l1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  dual_port_regfile_be #(
    .WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .READ_LATENCY(2)
  ) u_dut_l2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] COLLIDE_EXP = 32'hAABB0304;
`else
  localparam logic [31:0] COLLIDE_EXP = 32'h01020304;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Expected output state: last delivered word per instance, plus the one
  // request still in flight for the 2-cycle instance.
  logic [31:0] hold1;
  logic [31:0] hold2;
  logic        pend_v;
  logic [31:0] pend_d;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] be, input logic [3:0] wa,
                       input logic [31:0] wd, input logic re, input logic [3:0] ra);
    bus1.wr_en = we; bus1.wr_be = be; bus1.wr_addr = wa; bus1.wr_data = wd;
    bus1.rd_en = re; bus1.rd_addr = ra;
    bus2.wr_en = we; bus2.wr_be = be; bus2.wr_addr = wa; bus2.wr_data = wd;
    bus2.rd_en = re; bus2.rd_addr = ra;
  endtask

  // One clock of stimulus; ev/ed say whether this read should be accepted and
  // with which word. Outputs are checked on the following falling edge.
  task automatic step(input logic we, input logic [3:0] be, input logic [3:0] wa,
                      input logic [31:0] wd, input logic re, input logic [3:0] ra,
                      input logic ev, input logic [31:0] ed);
    logic        v1;
    logic        v2;
    logic [31:0] d1;
    logic [31:0] d2;
    drive(we, be, wa, wd, re, ra);
    $display("t=%0t wr=%0b be=%h wa=%0d wd=%08h rd=%0b ra=%0d exp_acc=%0b exp=%08h",
             $time, we, be, wa, wd, re, ra, ev, ed);
    @(posedge clk);
    @(negedge clk);
    v1     = ev;
    d1     = ev ? ed : hold1;
    hold1  = d1;
    v2     = pend_v;
    d2     = pend_v ? pend_d : hold2;
    hold2  = d2;
    pend_v = ev;
    pend_d = ed;
    check_eq("l1_rd_valid", 32'(bus1.rd_valid), 32'(v1));
    check_eq("l1_rd_data",  bus1.rd_data, d1);
    check_eq("l2_rd_valid", 32'(bus2.rd_valid), 32'(v2));
    check_eq("l2_rd_data",  bus2.rd_data, d2);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [3:0] ra, input logic [31:0] ed);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, ra, 1'b1, ed);
  endtask

  task automatic wr(input logic [3:0] wa, input logic [3:0] be, input logic [31:0] wd);
    step(1'b1, be, wa, wd, 1'b0, 4'd0, 1'b0, 32'h0);
  endtask

  // Called on a falling edge; reset is applied on the very next rising edge.
  task automatic do_reset();
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0);
    rst = 1'b1;
    $display("t=%0t reset", $time);
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    hold1  = 32'h0;
    hold2  = 32'h0;
    pend_v = 1'b0;
    pend_d = 32'h0;
    check_eq("rst_l1_busy",     32'(bus1.busy), 32'd1);
    check_eq("rst_l2_busy",     32'(bus2.busy), 32'd1);
    check_eq("rst_l1_rd_valid", 32'(bus1.rd_valid), 32'd0);
    check_eq("rst_l2_rd_valid", 32'(bus2.rd_valid), 32'd0);
    check_eq("rst_l1_rd_data",  bus1.rd_data, 32'h0);
    check_eq("rst_l2_rd_data",  bus2.rd_data, 32'h0);
  endtask

  task automatic wait_ready(input int exp_cycles);
    int n = 0;
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0);
    while ((bus1.busy || bus2.busy) && n < 200) begin
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    $display("t=%0t clear done after %0d busy cycles", $time, n);
    check_eq("busy_cycles", 32'(n), 32'(exp_cycles));
    check_eq("l1_busy_low", 32'(bus1.busy), 32'd0);
    check_eq("l2_busy_low", 32'(bus2.busy), 32'd0);
  endtask

  initial begin
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0);
    @(negedge clk);

    // Reset, clear length, all entries read zero back-to-back.
    do_reset();
    wait_ready(16);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'h0);
    idle();
    idle();

    // Byte-enable merge and zero mask.
    wr(4'd3, 4'hF, 32'hDEADBEEF);
    wr(4'd3, 4'h5, 32'h11223344);
    rd(4'd3, 32'hDE22BE44);
    wr(4'd3, 4'h0, 32'hFFFFFFFF);
    rd(4'd3, 32'hDE22BE44);

    // Same-cycle same-address write and read.
    wr(4'd5, 4'hF, 32'h01020304);
    step(1'b1, 4'hC, 4'd5, 32'hAABBCCDD, 1'b1, 4'd5, 1'b1, COLLIDE_EXP);
    rd(4'd5, 32'hAABB0304);

    // Pipelined reads in order, with an independent write to another address.
    wr(4'd0, 4'hF, 32'hA0A0A0A0);
    wr(4'd1, 4'hF, 32'hB1B1B1B1);
    wr(4'd2, 4'h3, 32'hC2C2C2C2);
    step(1'b1, 4'hF, 4'd9, 32'h99999999, 1'b1, 4'd0, 1'b1, 32'hA0A0A0A0);
    rd(4'd1, 32'hB1B1B1B1);
    rd(4'd2, 32'h0000C2C2);
    rd(4'd9, 32'h99999999);
    idle();

    // Last address with a non-contiguous mask.
    wr(4'd15, 4'h9, 32'h12345678);
    rd(4'd15, 32'h12000078);
    idle();
    idle();

    // Reset one cycle after a read request: the 2-cycle read is dropped.
    rd(4'd3, 32'hDE22BE44);
    do_reset();

    // Requests while busy are ignored (addr 0 and 1 were already cleared).
    step(1'b1, 4'hF, 4'd7, 32'h77777777, 1'b1, 4'd7, 1'b0, 32'h0);
    step(1'b1, 4'hF, 4'd0, 32'h55555555, 1'b1, 4'd0, 1'b0, 32'h0);
    step(1'b1, 4'hF, 4'd1, 32'h66666666, 1'b1, 4'd1, 1'b0, 32'h0);
    wait_ready(13);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'h0);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
